// File: rtl/mod_hash_seq_pkg.sv
// Shared definitions for the double-SHA256 command sequencer and the hash core it drives.
// Holds the command codes, H-buffer / message-buffer select encodings, the program
// length, the per-step table entry type and the sequencer FSM state type.
package mod_hash_seq_pkg;

    // Command codes on the core's CMD bus (8-bit native encoding).
    typedef enum logic [7:0] {
        CmdIdle      = 8'd0,
        CmdLoadH     = 8'd10,
        CmdHash      = 8'd20,
        CmdSumStoreH = 8'd30,
        CmdSumStoreM = 8'd40,
        CmdGetDigest = 8'd50
    } cmd_e;

    // H-buffer select: IV constants or the stored block-1 midstate.
    typedef enum logic {
        HSelIv  = 1'b0,
        HSelMid = 1'b1
    } h_sel_e;

    // Message buffer select.
    typedef enum logic [1:0] {
        BlkSel1      = 2'd0,
        BlkSel2      = 2'd1,
        BlkSelDigest = 2'd2
    } blk_sel_e;

    localparam int unsigned NumSteps = 9;

    localparam logic [3:0] StepFirst     = 4'd0;
    localparam logic [3:0] StepMidStore  = 4'd2;  // SUM_STORE_H: midstate is written
    localparam logic [3:0] StepMidResume = 4'd3;  // first step after block 1
    localparam logic [3:0] StepLast      = 4'(NumSteps - 1);

    typedef struct packed {
        cmd_e     cmd;
        h_sel_e   h_sel;
        blk_sel_e blk_sel;
    } step_entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StIssue,
        StRelease,
        StGap
    } state_e;

endpackage

// File: rtl/mod_hash_seq_rom.sv
// Program table for the double-SHA256 sequence: maps a step index to the command and
// the buffer selects that must be presented to the core for that step.
//   step  : program step, 0..8 (out-of-range steps decode to an idle entry)
//   entry : {cmd, h_sel, blk_sel} for that step
module mod_hash_seq_rom
    import mod_hash_seq_pkg::*;
(
    input  logic [3:0]  step,
    output step_entry_t entry
);

    always_comb begin
        entry = '{CmdIdle, HSelIv, BlkSel1};
        case (step)
            // Block 1 from the IV; the sum becomes the midstate.
            4'd0:    entry = '{CmdLoadH,     HSelIv,  BlkSel1};
            4'd1:    entry = '{CmdHash,      HSelIv,  BlkSel1};
            4'd2:    entry = '{CmdSumStoreH, HSelIv,  BlkSel1};
            // Block 2 from the midstate; the sum lands in the digest block buffer.
            4'd3:    entry = '{CmdLoadH,     HSelMid, BlkSel2};
            4'd4:    entry = '{CmdHash,      HSelMid, BlkSel2};
            4'd5:    entry = '{CmdSumStoreM, HSelMid, BlkSelDigest};
            // Second SHA256 over the 32-byte intermediate digest.
            4'd6:    entry = '{CmdLoadH,     HSelIv,  BlkSelDigest};
            4'd7:    entry = '{CmdHash,      HSelIv,  BlkSelDigest};
            4'd8:    entry = '{CmdGetDigest, HSelIv,  BlkSelDigest};
            default: entry = '{CmdIdle,      HSelIv,  BlkSel1};
        endcase
    end

endmodule

// File: rtl/mod_hash_seq.sv
// Command sequencer for the windowed SHA256 core. Steps the core through the fixed
// double-SHA256 program for one 80-byte header, one CMD/RDY handshake per step.
// Buffer selects are updated one cycle before a command is driven and held until CMD
// returns to IDLE.
//
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   START       : begin a program (sampled only when idle)
//   FLUSH       : invalidate the stored midstate, any state
//   RDY         : core ready level
//   CMD         : registered command to the core
//   H_SEL       : H-buffer select (0 = IV, 1 = midstate)
//   BLK_SEL     : message buffer select (0 = block1, 1 = block2, 2 = digest block)
//   STEP        : current program step (debug)
//   BUSY        : program in progress
//   DONE        : one-cycle pulse at program completion
//   MID_VALID   : midstate buffer holds a valid block-1 result
//
// Optional feature macro MOD_HASH_SEQ_MIDSTATE_EN: when defined, a START seen with
// MID_VALID set resumes at step 3 and skips block 1.
module mod_hash_seq
    import mod_hash_seq_pkg::*;
#(
    parameter int unsigned CMD_W       = 8,
    parameter int unsigned RELEASE_GAP = 1   // 0..15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             FLUSH,
    input  logic             RDY,
    output logic [CMD_W-1:0] CMD,
    output logic             H_SEL,
    output logic [1:0]       BLK_SEL,
    output logic [3:0]       STEP,
    output logic             BUSY,
    output logic             DONE,
    output logic             MID_VALID
);

    localparam bit         GapZero = (RELEASE_GAP == 0);
    localparam logic [3:0] GapLast = 4'(RELEASE_GAP - 1);

    state_e           state_q;
    logic [CMD_W-1:0] cmd_q;
    h_sel_e           h_sel_q;
    blk_sel_e         blk_sel_q;
    logic [3:0]       step_q;
    logic             busy_q;
    logic             done_q;
    logic             mid_valid_q;
    logic             armed_q;    // RDY has been low since CMD was driven
    logic [3:0]       gap_cnt_q;

    logic [3:0]  start_step;
    logic [3:0]  step_inc;
    logic [3:0]  rom_step;
    step_entry_t rom_entry;
    logic        accept;
    logic        advance;

    mod_hash_seq_rom u_rom (
        .step  (rom_step),
        .entry (rom_entry)
    );

    always_comb begin
        start_step = StepFirst;
`ifdef MOD_HASH_SEQ_MIDSTATE_EN
        if (mid_valid_q) begin
            start_step = StepMidResume;
        end
`endif
        step_inc = step_q + 4'd1;

        // The selects are loaded on entry to StSetup (from the step about to be
        // entered); the command is loaded on leaving StSetup (current step).
        rom_step = step_inc;
        if (state_q == StIdle) begin
            rom_step = start_step;
        end else if (state_q == StSetup) begin
            rom_step = step_q;
        end

        accept = (state_q == StIssue) && RDY && armed_q;

        advance = 1'b0;
        if (state_q == StRelease) begin
            advance = GapZero && !RDY;
        end else if (state_q == StGap) begin
            advance = (gap_cnt_q == GapLast);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            h_sel_q   <= HSelIv;
            blk_sel_q <= BlkSel1;
            step_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (START) begin
                        busy_q    <= 1'b1;
                        step_q    <= start_step;
                        h_sel_q   <= rom_entry.h_sel;
                        blk_sel_q <= rom_entry.blk_sel;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    cmd_q   <= CMD_W'(rom_entry.cmd);
                    // A RDY already high here is left over from before; it only
                    // counts once it has been seen low.
                    armed_q <= ~RDY;
                    state_q <= StIssue;
                end
                StIssue: begin
                    if (accept) begin
                        cmd_q   <= '0;
                        state_q <= StRelease;
                    end else if (!RDY) begin
                        armed_q <= 1'b1;
                    end
                end
                StRelease, StGap: begin
                    if (advance) begin
                        if (step_q == StepLast) begin
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            h_sel_q   <= HSelIv;
                            blk_sel_q <= BlkSel1;
                            state_q   <= StIdle;
                        end else begin
                            step_q    <= step_inc;
                            h_sel_q   <= rom_entry.h_sel;
                            blk_sel_q <= rom_entry.blk_sel;
                            state_q   <= StSetup;
                        end
                    end else if (state_q == StRelease) begin
                        if (!RDY) begin
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FLUSH takes priority over a same-cycle midstate write.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            mid_valid_q <= 1'b0;
        end else if (accept && (step_q == StepMidStore)) begin
            mid_valid_q <= 1'b1;
        end
    end

    assign CMD       = cmd_q;
    assign H_SEL     = h_sel_q;
    assign BLK_SEL   = blk_sel_q;
    assign STEP      = step_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign MID_VALID = mid_valid_q;

endmodule

// File: tb/tb_mod_hash_seq.sv
// Self-checking bench for mod_hash_seq: a bench-side core model answers each command
// after a (fixed or random) latency; expected commands/selects come from a step model.
module tb_mod_hash_seq;

    localparam int unsigned CMD_W = 8;
    localparam int unsigned GAP   = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             START;
    logic             FLUSH;
    logic             RDY;
    logic [CMD_W-1:0] CMD;
    logic             H_SEL;
    logic [1:0]       BLK_SEL;
    logic [3:0]       STEP;
    logic             BUSY;
    logic             DONE;
    logic             MID_VALID;

    int n_vec     = 0;
    int n_err     = 0;
    int done_seen = 0;
    bit mid_model = 1'b0;

    always #5 CLK = ~CLK;

    mod_hash_seq #(
        .CMD_W       (CMD_W),
        .RELEASE_GAP (GAP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .FLUSH     (FLUSH),
        .RDY       (RDY),
        .CMD       (CMD),
        .H_SEL     (H_SEL),
        .BLK_SEL   (BLK_SEL),
        .STEP      (STEP),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .MID_VALID (MID_VALID)
    );

    always @(posedge CLK) begin
        if (DONE) done_seen <= done_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Program model: three blocks of (load, hash, finish); finishing op differs per block.
    function automatic int exp_cmd(input int s);
        int phase = s % 3;
        int blk   = s / 3;
        if (phase == 0) return 10;
        if (phase == 1) return 20;
        return 30 + 10 * blk;
    endfunction

    function automatic int exp_h(input int s);
        return ((s / 3) == 1) ? 1 : 0;
    endfunction

    function automatic int exp_blk(input int s);
        if (s >= 5) return 2;
        if (s >= 3) return 1;
        return 0;
    endfunction

    function automatic int first_step();
`ifdef MOD_HASH_SEQ_MIDSTATE_EN
        return mid_model ? 3 : 0;
`else
        return 0;
`endif
    endfunction

    // fixed_lat = 0 selects a random answer latency; abort_at < 0 runs to completion.
    task automatic run_prog(input int fixed_lat, input bit stale, input int abort_at,
                            input bit flush_on_store);
        int s0 = first_step();
        int lat;
        int cnt;
        int done_before = done_seen;
        bit hit;

        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("busy_on_start", 32'(BUSY), 1);

        for (int s = s0; s < 9; s++) begin
            cnt = 0;
            hit = 1'b0;
            for (int i = 0; i < 64 && !hit; i++) begin
                @(negedge CLK);
                if (CMD != 0) begin
                    hit = 1'b1;
                end else begin
                    cnt++;
                    if (stale && s == 1 && cnt == 1) RDY = 1'b1;
                end
            end
            if (!hit) begin
                check($sformatf("cmd_timeout_s%0d", s), 32'(hit), 1);
                return;
            end
            if (s > s0) check($sformatf("idle_gap_s%0d", s), cnt, 1 + GAP);
            check($sformatf("cmd_s%0d", s), 32'(CMD), exp_cmd(s));
            check($sformatf("hsel_s%0d", s), 32'(H_SEL), exp_h(s));
            check($sformatf("blk_s%0d", s), 32'(BLK_SEL), exp_blk(s));
            check($sformatf("step_s%0d", s), 32'(STEP), s);
            check($sformatf("busy_s%0d", s), 32'(BUSY), 1);

            if (s == abort_at) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                mid_model = 1'b0;
                check("abort_cmd", 32'(CMD), 0);
                check("abort_busy", 32'(BUSY), 0);
                check("abort_mid", 32'(MID_VALID), 0);
                check("abort_step", 32'(STEP), 0);
                return;
            end

            if (stale && s == 1) begin
                repeat (6) @(negedge CLK);
                check("stale_hold_cmd", 32'(CMD), 20);
                check("stale_hold_step", 32'(STEP), 1);
                RDY = 1'b0;
                @(negedge CLK);
                check("stale_low_cmd", 32'(CMD), 20);
                RDY = 1'b1;
            end else begin
                lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
                for (int i = 1; i < lat; i++) begin
                    @(negedge CLK);
                    check($sformatf("hold_cmd_s%0d", s), 32'(CMD), exp_cmd(s));
                    check($sformatf("hold_hsel_s%0d", s), 32'(H_SEL), exp_h(s));
                    check($sformatf("hold_blk_s%0d", s), 32'(BLK_SEL), exp_blk(s));
                end
                RDY = 1'b1;
                if (flush_on_store && s == 2) FLUSH = 1'b1;
            end

            hit = 1'b0;
            for (int i = 0; i < 32 && !hit; i++) begin
                @(negedge CLK);
                FLUSH = 1'b0;
                if (CMD == 0) hit = 1'b1;
            end
            if (!hit) begin
                check($sformatf("release_timeout_s%0d", s), 32'(hit), 1);
                RDY = 1'b0;
                return;
            end
            if (s == 2) mid_model = !flush_on_store;
            check($sformatf("mid_valid_s%0d", s), 32'(MID_VALID), 32'(mid_model));

            lat = int'($urandom_range(0, 2));
            for (int i = 0; i < lat; i++) begin
                @(negedge CLK);
                check($sformatf("release_hold_s%0d", s), 32'(CMD), 0);
            end
            RDY = 1'b0;
        end

        hit = 1'b0;
        for (int i = 0; i < 32 && !hit; i++) begin
            @(negedge CLK);
            if (DONE) hit = 1'b1;
        end
        check("done_seen", 32'(hit), 1);
        if (!hit) return;
        check("busy_at_done", 32'(BUSY), 0);
        @(negedge CLK);
        check("done_pulse_end", 32'(DONE), 0);
        check("done_count", done_seen - done_before, 1);
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        FLUSH = 1'b0;
        RDY   = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_cmd", 32'(CMD), 0);
        check("rst_hsel", 32'(H_SEL), 0);
        check("rst_blk", 32'(BLK_SEL), 0);
        check("rst_step", 32'(STEP), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_mid", 32'(MID_VALID), 0);
        RST = 1'b0;

        run_prog(5, 1'b1, -1, 1'b0);  // fixed latency, stale RDY at the first HASH
        run_prog(0, 1'b0, -1, 1'b0);  // resumes from the midstate when enabled

        @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        mid_model = 1'b0;
        check("flush_mid", 32'(MID_VALID), 0);

        run_prog(0, 1'b0, -1, 1'b0);  // full program again after the flush
        run_prog(0, 1'b0, 4, 1'b0);   // reset during step 4 (HASH)
        run_prog(0, 1'b0, -1, 1'b1);  // restart at step 0; FLUSH beats the midstate write
        run_prog(0, 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
